// File: rtl/weave_if.sv
// Host <-> weave_engine bundle: frame control, table configuration and pixel stream.
// Pixel stream: a pixel transfers on any rising edge where pix_valid && pix_ready;
// once pix_valid is high it and pix_data/pix_x/pix_y/frame_last stay put until that transfer.
interface weave_if #(
  parameter int SHAFTS = 4,
  parameter int P_W    = 3,
  parameter int COL_W  = 6,
  parameter int ROW_W  = 6
) ();
  logic              start;
  logic [1:0]        mode;
  logic              cfg_we;
  logic              cfg_sel;
  logic [P_W-1:0]    cfg_addr;
  logic [SHAFTS-1:0] cfg_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_data;
  logic [COL_W-1:0]  pix_x;
  logic [ROW_W-1:0]  pix_y;
  logic              frame_last;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, cfg_we, cfg_sel, cfg_addr, cfg_data, pix_ready,
    input  pix_valid, pix_data, pix_x, pix_y, frame_last, busy, done
  );

  modport slave (
    input  start, mode, cfg_we, cfg_sel, cfg_addr, cfg_data, pix_ready,
    output pix_valid, pix_data, pix_x, pix_y, frame_last, busy, done
  );
endinterface

// File: rtl/weave_engine.sv
// Loom draft renderer: streams a raster frame of warp-up bits from a threading
// table and a liftplan (or a fixed plain/twill rule), one pixel per cycle.
module weave_engine #(
  parameter int SHAFTS = 4,
  parameter int P_W    = 3,
  parameter int COL_W  = 6,
  parameter int ROW_W  = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  weave_if.slave   bus,
  output logic     dbg_state
);

  localparam int P  = 1 << P_W;
  localparam int TW = (SHAFTS > 1) ? $clog2(SHAFTS) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic [TW-1:0]     thr  [P];
  logic [SHAFTS-1:0] lift [P];
  logic [COL_W-1:0]  nx;
  logic [ROW_W-1:0]  ny;

  assign dbg_state = state;

  // Threading entries beyond the shaft count fold back once; the raw value is < 2*SHAFTS.
  function automatic logic [TW-1:0] fold(input logic [TW-1:0] v);
    if (int'(v) >= SHAFTS) return TW'(int'(v) - SHAFTS);
    return v;
  endfunction

  function automatic logic pix_fn(input logic [1:0] m, input logic [COL_W-1:0] fx,
                                  input logic [ROW_W-1:0] fy);
    logic [COL_W:0]  sum;
    logic [P_W-1:0]  xm;
    logic [P_W-1:0]  ym;
    logic            tb_bit;
    sum    = {1'b0, fx} + (COL_W+1)'(fy);
    xm     = fx[P_W-1:0];
    ym     = fy[P_W-1:0];
    tb_bit = lift[ym][thr[xm]];
    case (m)
      2'd0:    return fx[0] ^ fy[0];
      2'd1:    return sum[1];
      2'd2:    return tb_bit;
      default: return ~tb_bit;
    endcase
  endfunction

  always_comb begin
    nx = bus.pix_x + COL_W'(1);
    ny = (&bus.pix_x) ? bus.pix_y + ROW_W'(1) : bus.pix_y;
  end

  // Tables reset to a straight twill; locked while a frame is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < P; i++) begin
        thr[i]  <= TW'(i % SHAFTS);
        lift[i] <= SHAFTS'(1) << (i % SHAFTS);
      end
    end else if (bus.cfg_we && !bus.busy) begin
      if (bus.cfg_sel) lift[bus.cfg_addr] <= bus.cfg_data;
      else             thr[bus.cfg_addr]  <= fold(bus.cfg_data[TW-1:0]);
    end
  end

  // Pixel outputs are precomputed one step ahead, so a transfer is followed
  // immediately by the next pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mode_q         <= 2'd0;
      bus.pix_valid  <= 1'b0;
      bus.pix_data   <= 1'b0;
      bus.pix_x      <= '0;
      bus.pix_y      <= '0;
      bus.frame_last <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state          <= RUN;
            mode_q         <= bus.mode;
            bus.pix_x      <= '0;
            bus.pix_y      <= '0;
            bus.pix_data   <= pix_fn(bus.mode, '0, '0);
            bus.frame_last <= 1'b0;
            bus.pix_valid  <= 1'b1;
            bus.busy       <= 1'b1;
          end
        end
        RUN: begin
          if (bus.pix_valid && bus.pix_ready) begin
            if (bus.frame_last) begin
              state          <= IDLE;
              bus.pix_valid  <= 1'b0;
              bus.frame_last <= 1'b0;
              bus.busy       <= 1'b0;
              bus.done       <= 1'b1;
            end else begin
              bus.pix_x      <= nx;
              bus.pix_y      <= ny;
              bus.pix_data   <= pix_fn(mode_q, nx, ny);
              bus.frame_last <= (&nx) && (&ny);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/weave_engine.md
WEAVE_ENGINE -- requirements
Module: weave_engine

Interface
REQ-001 SHALL have parameter SHAFTS, default 4, number of loom shafts (legal 2..8).
REQ-002 SHALL have parameter P_W, default 3, log2 of pattern repeat length P = 2^P_W (legal 1..4).
REQ-003 SHALL have parameter COL_W, default 6, column counter width; frame width 2^COL_W.
REQ-004 SHALL have parameter ROW_W, default 6, row counter width; frame height 2^ROW_W.
REQ-005 SHALL have the following ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  frame start request.
- mode  in  2  pattern mode, sampled at accepted start.
- cfg_we  in  1  table write strobe.
- cfg_sel  in  1  table select: 0 threading, 1 liftplan.
- cfg_addr  in  P_W  table entry index.
- cfg_data  in  SHAFTS  write data.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  consumer accepts pixel.
- pix_data  out  1  pixel value: 1 = warp up.
- pix_x  out  COL_W  pixel column.
- pix_y  out  ROW_W  pixel row.
- frame_last  out  1  high with final pixel of frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.

Function
REQ-006 SHALL hold threading table T[0..P-1], each entry a shaft index of clog2(SHAFTS) bits.
REQ-007 SHALL hold liftplan table L[0..P-1], each entry SHAFTS bits, where bit s = shaft s lifted.
REQ-008 SHALL, when cfg_we=1 and busy=0 and cfg_sel=0, write T[cfg_addr] with the low clog2(SHAFTS) bits of cfg_data; an index >= SHAFTS SHALL be stored as (value mod SHAFTS).
REQ-009 SHALL, when cfg_we=1 and busy=0 and cfg_sel=1, write L[cfg_addr] with cfg_data.
REQ-010 SHALL ignore cfg_we while busy=1; table contents SHALL be unchanged.
REQ-011 SHALL implement FSM states IDLE and RUN.
- IDLE -> RUN on start=1.
- RUN -> IDLE on the transfer with frame_last=1.
- start SHALL be ignored in RUN.
REQ-012 SHALL, on an accepted start, latch mode, set x=0 and y=0, and assert pix_valid on the next cycle together with busy=1.
REQ-013 SHALL transfer a pixel in any cycle with pix_valid=1 and pix_ready=1.
REQ-014 SHALL hold pix_data, pix_x, pix_y and frame_last stable while pix_valid=1 and pix_ready=0.
REQ-015 SHALL, after a non-final transfer, present the next pixel in the following cycle, giving full throughput of 1 pixel/cycle under constant pix_ready=1.
REQ-016 SHALL advance raster order: x increments; on x wrapping from 2^COL_W-1 to 0, y increments.
REQ-017 SHALL assert frame_last exactly when x=2^COL_W-1 and y=2^ROW_W-1.
REQ-018 SHALL compute pix_data from the latched mode, with xm = x mod P and ym = y mod P:
- 0 plain: x[0] XOR y[0].
- 1 2/2 twill: bit 1 of (x+y), computed in COL_W+1 bits.
- 2 table: L[ym][T[xm]].
- 3 inverted table: NOT L[ym][T[xm]].
REQ-019 SHALL, after the final transfer, deassert pix_valid and busy in the next cycle and pulse done=1 for exactly that one cycle.
REQ-020 SHALL accept a start in the same cycle that done=1.
REQ-021 SHALL let table writes made in the done cycle take effect.

Reset
REQ-022 SHALL, while rst_n=0, force the FSM to IDLE, with pix_valid=0, pix_data=0, pix_x=0, pix_y=0, frame_last=0, busy=0, done=0, and latched mode=0.
REQ-023 SHALL reset T[c] = c mod SHAFTS and L[r] = 1 << (r mod SHAFTS), so the default table pattern is a straight twill.
REQ-024 SHALL abort a frame on reset asserted mid-RUN, with no done pulse; after release the block is IDLE and awaits a new start.

Verification
REQ-025 Bench SHALL cover plain weave: defaults, mode=0, start, pix_ready=1 held -> 4096 pixels, pix_data(x,y) = x[0]^y[0], frame_last only at (63,63), done pulse 1 cycle later, busy low.
REQ-026 Bench SHALL cover the default table: mode=2 -> pixel(x,y)=1 iff (x mod 8) mod 4 == (y mod 8) mod 4; mode=3 gives the complement.
REQ-027 Bench SHALL cover custom tables: write T[k]=0 for all k and L[0]=4'b0001, L[1..7]=0, mode=2 -> pixel=1 only on rows with y mod 8 = 0.
REQ-028 Bench SHALL cover backpressure: random pix_ready at 30% -> output fields stable while stalled; sequence identical to the no-stall run; exactly 4096 transfers.
REQ-029 Bench SHALL cover config during RUN: cfg_we mid-frame plus a second start mid-frame -> frame unaffected and tables unchanged afterward.
REQ-030 Bench SHALL cover mid-frame reset: rst_n low at pixel 100 -> outputs go to reset values immediately, no done pulse; a new start restarts at (0,0).
